// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the instruction fetch/issue slice.
//   - IR_W           : instruction word width
//   - field ranges   : OP [15:12], F1 [11:8], F2 [7:4], F3 [3:0]
//   - opcode_t       : 4-bit opcode type plus named opcode constants
//   - field helpers  : small functions that pull fields out of an IR word
// ---------------------------------------------------------------------------
package ir_pkg;

    localparam int IR_W  = 16;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int F1_HI = 11;
    localparam int F1_LO = 8;
    localparam int F2_HI = 7;
    localparam int F2_LO = 4;
    localparam int F3_HI = 3;
    localparam int F3_LO = 0;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP = 4'b0000;
    localparam opcode_t OP_ADD = 4'b0001;
    localparam opcode_t OP_SUB = 4'b0010;
    localparam opcode_t OP_AND = 4'b0011;
    localparam opcode_t OP_OR  = 4'b0100;
    localparam opcode_t OP_LD  = 4'b1000;
    localparam opcode_t OP_ST  = 4'b1001;
    localparam opcode_t OP_LDI = 4'b1100;
    localparam opcode_t OP_BR  = 4'b1110;

    // Opcode field of an instruction word.
    function automatic opcode_t ir_op(input logic [IR_W-1:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    // Operand fields of an instruction word.
    function automatic logic [3:0] ir_f1(input logic [IR_W-1:0] ir);
        return ir[F1_HI:F1_LO];
    endfunction

    function automatic logic [3:0] ir_f2(input logic [IR_W-1:0] ir);
        return ir[F2_HI:F2_LO];
    endfunction

    function automatic logic [3:0] ir_f3(input logic [IR_W-1:0] ir);
        return ir[F3_HI:F3_LO];
    endfunction

endpackage

// File: rtl/ir_fetch_issue_fifo.sv
// ---------------------------------------------------------------------------
// ir_fifo
// Synchronous FIFO holding {PC, instruction} pairs between the instruction
// memory response and the decoder handshake.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle
//   push_data  : entry to write
//   pop        : consume the head entry this cycle
//   flush      : discard all entries; wins over a simultaneous push
//   count      : current occupancy (0..DEPTH)
//   head_data  : oldest entry, meaningful when count != 0
// Push and pop in the same cycle are accepted at any occupancy, including
// full: the popped slot is the one being overwritten, so nothing is lost.
// ---------------------------------------------------------------------------
module ir_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [W-1:0]                 head_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          not_empty_s;
    logic          not_full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic          wr_en_s;

    // Qualify push/pop against occupancy; a full FIFO still takes a push
    // when the head is popped in the same cycle.
    always_comb begin
        not_empty_s = (count_r != CW'(0));
        not_full_s  = (count_r != CW'(DEPTH));
        pop_ok_s    = pop & not_empty_s;
        push_ok_s   = push & (not_full_s | pop_ok_s);
        wr_en_s     = push_ok_s & ~flush & ~rst;
    end

    // Pointer and occupancy tracking; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/ir_fetch_issue.sv
// ---------------------------------------------------------------------------
// ir_fetch_issue
// Instruction fetch/issue unit feeding the decode stage with a 16-bit IR
// stream. Issues word-addressed reads to a synchronous instruction memory
// (1-cycle latency), buffers returned words with their PC, and presents
// them over a valid/ready handshake. A branch redirect flushes everything
// in flight and restarts fetch at the target.
//   CLK        : clock, all state on rising edge
//   RST        : synchronous active-high reset
//   FETCH_EN   : 1 = may issue new fetches, 0 = freeze fetch (buffer drains)
//   IMEM_EN    : instruction memory read strobe this cycle
//   IMEM_ADDR  : read address (current PC)
//   IMEM_RDATA : read data, valid the cycle after IMEM_EN
//   IR         : instruction to decoder (zero when IR_VALID=0)
//   IR_PC      : address IR was fetched from (zero when IR_VALID=0)
//   IR_VALID   : IR/IR_PC hold a valid instruction
//   IR_READY   : decoder accepts IR this cycle when IR_VALID=1
//   BR_TAKEN   : redirect request from execute
//   BR_TARGET  : redirect address
// ---------------------------------------------------------------------------
module ir_fetch_issue
    import ir_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FETCH_EN,
    output logic              IMEM_EN,
    output logic [PC_W-1:0]   IMEM_ADDR,
    input  logic [IR_W-1:0]   IMEM_RDATA,
    output logic [IR_W-1:0]   IR,
    output logic [PC_W-1:0]   IR_PC,
    output logic              IR_VALID,
    input  logic              IR_READY,
    input  logic              BR_TAKEN,
    input  logic [PC_W-1:0]   BR_TARGET
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PC_W + IR_W;

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] resp_pc_r;
    logic            inflight_r;
    logic            kill_r;

    logic [CW-1:0]   count_s;
    logic [EW-1:0]   head_s;
    logic [EW-1:0]   push_data_s;
    logic [CW:0]     occ_s;
    logic            valid_s;
    logic            pop_s;
    logic            push_s;
    logic            room_s;
    logic            issue_s;

    // Credit check: entries held plus the response arriving this cycle,
    // minus the entry leaving this cycle, must leave a free slot for the
    // word a new fetch would return next cycle. pop implies count>=1, so
    // the subtraction cannot underflow.
    always_comb begin
        valid_s     = (count_s != CW'(0));
        pop_s       = valid_s & IR_READY;
        occ_s       = (CW+1)'(count_s) + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
        room_s      = (occ_s < (CW+1)'(DEPTH));
        issue_s     = FETCH_EN & ~BR_TAKEN & ~RST & room_s;
        push_s      = inflight_r & ~kill_r;
        push_data_s = {resp_pc_r, IMEM_RDATA};
    end

    // PC, in-flight and kill tracking; redirect overrides any issue.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r       <= PC_W'(RESET_PC);
            resp_pc_r  <= PC_W'(0);
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            kill_r     <= BR_TAKEN & inflight_r;
            if (BR_TAKEN) begin
                pc_r <= BR_TARGET;
            end else if (issue_s) begin
                pc_r <= pc_r + PC_W'(1);
            end else begin
                pc_r <= pc_r;
            end
            if (issue_s) begin
                resp_pc_r <= pc_r;
            end else begin
                resp_pc_r <= resp_pc_r;
            end
        end
    end

    ir_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (BR_TAKEN),
        .count     (count_s),
        .head_data (head_s)
    );

    // Decoder-facing outputs come straight from FIFO registers; IR and
    // IR_PC are forced to zero while nothing valid is held.
    always_comb begin
        IMEM_EN   = issue_s;
        IMEM_ADDR = pc_r;
        IR_VALID  = valid_s;
        if (valid_s) begin
            IR    = head_s[IR_W-1:0];
            IR_PC = head_s[EW-1:IR_W];
        end else begin
            IR    = {IR_W{1'b0}};
            IR_PC = {PC_W{1'b0}};
        end
    end

endmodule
